// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through every input row, samples its output after a settle
// interval, and scores the resulting truth table against a latched expected code.
//
// state  | meaning
// IDLE   | waiting for start; dut_in holds its last value
// SETTLE | dut_in driven, counting settle cycles down to terminal count
// SAMPLE | capture dut_out into the shadow table, advance or finish
// DONE   | one-cycle done pulse; results published on entry
module truth_table_sweeper #(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [(1<<N_IN)-1:0]   expected,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic                   match,
   output logic [N_IN:0]          mismatch_cnt
);

   localparam int              ROWS        = 1 << N_IN;
   localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [N_IN:0]   LAST_ROW    = (N_IN+1)'(ROWS - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE_CYCLES must be 1..255");
   end

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t            state;
   logic [N_IN:0]     row;
   logic [7:0]        settle_cnt;
   logic [ROWS-1:0]   exp_q;
   logic [ROWS-1:0]   shadow;
   logic [ROWS-1:0]   shadow_nxt;
   logic [ROWS-1:0]   diff;
   logic [N_IN-1:0]   bit_idx;
   logic [N_IN:0]     pop;

   // Row r lands in bit ROWS-1-r, which is the bitwise inverse of r.
   always_comb begin
      bit_idx             = ~row[N_IN-1:0];
      shadow_nxt          = shadow;
      shadow_nxt[bit_idx] = dut_out;
      diff                = shadow_nxt ^ exp_q;
      pop                 = '0;
      for (int i = 0; i < ROWS; i++) begin
         pop = pop + (N_IN+1)'(diff[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         row          <= '0;
         settle_cnt   <= '0;
         exp_q        <= '0;
         shadow       <= '0;
         dut_in       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         table_out    <= '0;
         match        <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  row        <= '0;
                  dut_in     <= '0;
                  settle_cnt <= SETTLE_LOAD;
                  exp_q      <= expected;
                  shadow     <= '0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  dut_in <= '0;
               end else if (settle_cnt == 8'd0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  dut_in <= '0;
               end else begin
                  shadow <= shadow_nxt;
                  if (row == LAST_ROW) begin
                     state        <= DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     table_out    <= shadow_nxt;
                     match        <= (shadow_nxt == exp_q);
                     mismatch_cnt <= pop;
                  end else begin
                     state      <= SETTLE;
                     row        <= row + 1'b1;
                     dut_in     <= row[N_IN-1:0] + 1'b1;
                     settle_cnt <= SETTLE_LOAD;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
